// File: rtl/led_zone_if.sv
// Bus between led_zone_sender, the LED-zone FIFO read port and the serial LED driver link.
interface led_zone_if #(
    parameter int unsigned DATA_W = 8
);
    logic              frame_start;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_rd_empty;
    logic              led_sclk;
    logic              led_sdo;
    logic              led_latch;
    logic              busy;
    logic [9:0]        zone_cnt;
    logic              underrun;
    logic              frame_drop;

    modport master (
        output frame_start, fifo_rd_data, fifo_rd_empty,
        input  fifo_rd_en, led_sclk, led_sdo, led_latch, busy, zone_cnt, underrun, frame_drop
    );

    modport slave (
        input  frame_start, fifo_rd_data, fifo_rd_empty,
        output fifo_rd_en, led_sclk, led_sdo, led_latch, busy, zone_cnt, underrun, frame_drop
    );
endinterface

// File: rtl/led_zone_sender.sv
// Drains ZONE_NUM bytes per frame from the LED-zone FIFO and shifts them MSB-first to the LED driver.
// Optional LED_CHECKSUM_EN appends a mod-2^DATA_W sum of the frame's bytes before the latch pulse.
module led_zone_sender #(
    parameter int unsigned ZONE_NUM     = 64,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned LATCH_CYC    = 4,
    parameter int unsigned UNDERRUN_CYC = 256
) (
    input  logic       rd_clk,
    input  logic       rd_rst,
    led_zone_if.slave  bus
);
    localparam int unsigned ZONE_W = 10;
    localparam int unsigned WAIT_W = $clog2(UNDERRUN_CYC + 1);
    localparam int unsigned DIV_W  = $clog2(CLK_DIV + 1);
    localparam int unsigned BIT_W  = $clog2(DATA_W + 1);
    localparam int unsigned LAT_W  = $clog2(LATCH_CYC + 1);

    typedef enum logic [2:0] {IDLE, WAIT, READ, LOAD, SHIFT, LATCH} state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic [DATA_W-1:0] shreg;
`ifdef LED_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
    logic              csum_pass;
`endif

    logic last_zone;
    logic half_done;
    logic last_bit;

    assign last_zone = (bus.zone_cnt == ZONE_W'(ZONE_NUM - 1));
    assign half_done = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign last_bit  = (bit_cnt == BIT_W'(DATA_W - 1));

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            div_cnt        <= '0;
            bit_cnt        <= '0;
            lat_cnt        <= '0;
            shreg          <= '0;
            bus.fifo_rd_en <= 1'b0;
            bus.led_sclk   <= 1'b0;
            bus.led_sdo    <= 1'b0;
            bus.led_latch  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.zone_cnt   <= '0;
            bus.underrun   <= 1'b0;
            bus.frame_drop <= 1'b0;
`ifdef LED_CHECKSUM_EN
            csum           <= '0;
            csum_pass      <= 1'b0;
`endif
        end else begin
            bus.fifo_rd_en <= 1'b0;
            // Any frame_start outside IDLE (including the LATCH->IDLE cycle) is dropped.
            bus.frame_drop <= bus.frame_start && (state != IDLE);

            case (state)
                IDLE: begin
`ifdef LED_CHECKSUM_EN
                    csum      <= '0;
                    csum_pass <= 1'b0;
`endif
                    if (bus.frame_start) begin
                        state        <= WAIT;
                        bus.busy     <= 1'b1;
                        bus.zone_cnt <= '0;
                        bus.underrun <= 1'b0;
                        wait_cnt     <= '0;
                    end
                end

                WAIT: begin
                    if (!bus.fifo_rd_empty) begin
                        state          <= READ;
                        bus.fifo_rd_en <= 1'b1;
                    end else if (wait_cnt == WAIT_W'(UNDERRUN_CYC - 1)) begin
                        state        <= IDLE;
                        bus.busy     <= 1'b0;
                        bus.underrun <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                READ: state <= LOAD;

                LOAD: begin
                    shreg        <= bus.fifo_rd_data;
                    bus.led_sdo  <= bus.fifo_rd_data[DATA_W-1];
                    bus.led_sclk <= 1'b0;
                    div_cnt      <= '0;
                    bit_cnt      <= '0;
`ifdef LED_CHECKSUM_EN
                    csum         <= csum + bus.fifo_rd_data;
`endif
                    state        <= SHIFT;
                end

                // Each bit: CLK_DIV cycles sclk low, then CLK_DIV cycles sclk high.
                SHIFT: begin
                    if (!half_done) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!bus.led_sclk) begin
                            bus.led_sclk <= 1'b1;
                        end else begin
                            bus.led_sclk <= 1'b0;
                            if (!last_bit) begin
                                bit_cnt     <= bit_cnt + BIT_W'(1);
                                shreg       <= shreg << 1;
                                bus.led_sdo <= shreg[DATA_W-2];
                            end else if (!last_zone) begin
                                bus.zone_cnt <= bus.zone_cnt + ZONE_W'(1);
                                bus.led_sdo  <= 1'b0;
                                wait_cnt     <= '0;
                                state        <= WAIT;
`ifdef LED_CHECKSUM_EN
                            end else if (!csum_pass) begin
                                csum_pass   <= 1'b1;
                                bit_cnt     <= '0;
                                shreg       <= csum;
                                bus.led_sdo <= csum[DATA_W-1];
`endif
                            end else begin
                                bus.led_sdo   <= 1'b0;
                                bus.led_latch <= 1'b1;
                                lat_cnt       <= '0;
                                state         <= LATCH;
                            end
                        end
                    end
                end

                LATCH: begin
                    if (lat_cnt == LAT_W'(LATCH_CYC - 1)) begin
                        bus.led_latch <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
